mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Sequential multiply/divide unit with HI/LO result registers, parametrised in WIDTH.
//  Sits beside the ALU in the execute stage and runs MULT/MULTU/DIV/DIVU over WIDTH+1 cycles.
//  Also executes MTHI/MTLO writes in a single cycle.
//  The control unit stalls on MDU_busy; an exception flush aborts an operation in flight.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width in bits; any value >= 4
// PORTS
//  MDU_clk        in   1      clock, rising edge
//  MDU_reset      in   1      synchronous reset, active-high
//  MDU_start      in   1      issue MDU_op; sampled on the clock edge
//  MDU_op         in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//  MDU_operand_1  in   WIDTH  multiplicand/dividend (rs); source for MTHI/MTLO
//  MDU_operand_2  in   WIDTH  multiplier/divisor (rt)
//  MDU_flush      in   1      abort the current operation (exception)
//  MDU_hi         out  WIDTH  HI register: product upper half, or remainder
//  MDU_lo         out  WIDTH  LO register: product lower half, or quotient
//  MDU_busy       out  1      operation in progress; start is ignored while set
//  MDU_done       out  1      one-cycle pulse; HI/LO updated for the finished op
//  MDU_div_zero   out  1      last finished DIV/DIVU had a zero divisor
// BEHAVIOUR
//  Reset: all outputs 0; HI/LO = 0; state IDLE. Reset dominates start and flush.
//  States: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  Start in IDLE, op = MULT..DIVU, at edge k:
//   - latch magnitudes of both operands (signed ops use abs value; unsigned use raw bits)
//   - latch the result-sign flags; go to CALC; set count = 0
//   - MDU_busy = 1 from edge k through edge k+WIDTH+1
//  CALC: one iteration per cycle.
//   - multiply: radix-2 shift-add over a 2*WIDTH accumulator
//   - divide: restoring shift-subtract
//   - after WIDTH iterations, go to FIX
//  FIX, edge k+WIDTH+1:
//   - apply sign correction and write HI/LO
//   - pulse MDU_done for one cycle; MDU_busy = 0 in the same cycle
//   - go to IDLE
//   - latency from start to done is WIDTH+1 cycles
//   - a new start is accepted in the MDU_done cycle
//  Sign rules:
//   - MULT: negate the 2*WIDTH product when the operand signs differ
//   - DIV: quotient negative when the operand signs differ; remainder takes the dividend's sign
//   - DIV of most-negative by -1: LO = 1<<(WIDTH-1), HI = 0; no overflow flag
//  Divide by zero (operand_2 == 0):
//   - full latency, no early exit
//   - LO = all ones; HI = operand_1 (raw); MDU_div_zero = 1
//  MDU_div_zero:
//   - cleared by any accepted MULT/MULTU/DIV/DIVU start
//   - otherwise held
//  MTHI/MTLO:
//   - with start in IDLE, HI (resp. LO) <= operand_1 at that edge
//   - no busy, no done
//  Reserved ops: start ignored.
//  Start while busy: ignored; operands and op are not re-latched.
//  Flush:
//   - returns to IDLE at the next edge; busy = 0
//   - HI/LO and div_zero are left unchanged; no done
//   - flush in the FIX cycle beats the write
//   - flush in IDLE is a no-op
//   - flush and start in the same IDLE cycle: flush wins, start is dropped
//  HI/LO change only on done, MTHI/MTLO, or reset.
// TESTING (WIDTH=32)
//  MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after start
//     HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles
//  MULT a=-7 (0xFFFFFFF9) b=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6
//  DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF
//     then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0
//  DIVU a=0x1234 b=0 -> LO=0xFFFFFFFF, HI=0x1234, div_zero=1
//     next MULTU start clears div_zero
//  Start MULT, pulse flush at cycle 10 -> busy=0 next cycle, no done, HI/LO unchanged
//     re-issue start with a second start pulsed while busy; the second start is ignored
//  MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A in back-to-back cycles -> HI/LO updated, no done
//     reset mid-DIV -> HI=LO=0, busy=0

Source files
------------

// File: rtl/mul_div_unit.sv
// Sequential multiply/divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO write in one cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             MDU_clk,
  input  logic             MDU_reset,
  input  logic             MDU_start,
  input  logic [2:0]       MDU_op,
  input  logic [WIDTH-1:0] MDU_operand_1,
  input  logic [WIDTH-1:0] MDU_operand_2,
  input  logic             MDU_flush,
  output logic [WIDTH-1:0] MDU_hi,
  output logic [WIDTH-1:0] MDU_lo,
  output logic             MDU_busy,
  output logic             MDU_done,
  output logic             MDU_div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;       // {product hi, product lo} or {remainder, quotient}
  logic [WIDTH-1:0]   divisor;   // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               zero_div;

  // Issue decode
  logic             start_ok, start_arith, start_mthi, start_mtlo;
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign start_ok    = MDU_start && (state == IDLE) && !MDU_flush;
  assign start_arith = start_ok && !MDU_op[2];
  assign start_mthi  = start_ok && (MDU_op == 3'b100);
  assign start_mtlo  = start_ok && (MDU_op == 3'b101);
  assign signed_op   = !MDU_op[0];
  assign a_neg       = signed_op && MDU_operand_1[WIDTH-1];
  assign b_neg       = signed_op && MDU_operand_2[WIDTH-1];
  assign a_mag       = a_neg ? -MDU_operand_1 : MDU_operand_1;
  assign b_mag       = b_neg ? -MDU_operand_2 : MDU_operand_2;
  assign MDU_busy    = (state != IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (start_arith) state_next = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (MDU_flush) state_next = IDLE;
  end

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, divisor};
    if (div_trial[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction. With a zero divisor the remainder path shifts the dividend
  // magnitude back out unchanged, so sign-correcting it restores the raw operand.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

  always_comb begin
    prod_fixed = neg_q ? -acc : acc;
    quo        = acc[WIDTH-1:0];
    rem        = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_lo = zero_div ? '1 : (neg_q ? -quo : quo);
      res_hi = neg_r ? -rem : rem;
    end else begin
      res_lo = prod_fixed[WIDTH-1:0];
      res_hi = prod_fixed[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge MDU_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (MDU_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge MDU_clk) begin
    if (MDU_reset) begin
      count        <= '0;
      acc          <= '0;
      divisor      <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      zero_div     <= 1'b0;
      MDU_hi       <= '0;
      MDU_lo       <= '0;
      MDU_done     <= 1'b0;
      MDU_div_zero <= 1'b0;
    end else begin
      MDU_done <= 1'b0;
      if (start_arith) begin
        acc          <= {{WIDTH{1'b0}}, a_mag};
        divisor      <= b_mag;
        is_div       <= MDU_op[1];
        neg_q        <= a_neg ^ b_neg;
        neg_r        <= a_neg;
        zero_div     <= MDU_op[1] && (MDU_operand_2 == '0);
        count        <= '0;
        MDU_div_zero <= 1'b0;
      end
      if (state == CALC) begin
        acc   <= is_div ? div_next : mul_next;
        count <= count + CW'(1);
      end
      if (state == FIX && !MDU_flush) begin
        MDU_hi       <= res_hi;
        MDU_lo       <= res_lo;
        MDU_done     <= 1'b1;
        MDU_div_zero <= zero_div;
      end
      if (start_mthi) MDU_hi <= MDU_operand_1;
      if (start_mtlo) MDU_lo <= MDU_operand_1;
    end
  end

endmodule
